fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/pc_register.sv | 30 +++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch stage: state encoding,
// operand-count field position and default opcode constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPER_LO = 2'd1,
    ST_OPER_HI = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_t;

  localparam int OPCNT_MSB = 7;
  localparam int OPCNT_LSB = 6;

  localparam logic [7:0] DEFAULT_NOP_OPCODE  = 8'h00;
  localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;

  // Encoding 3 is reserved and behaves like a two-byte operand.
  function automatic logic [1:0] operand_count(input logic [1:0] field);
    logic [1:0] cnt;
    if (field == 2'd3) begin
      cnt = 2'd2;
    end else begin
      cnt = field;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pc_register.sv
// 16-bit program counter: synchronous reset, load, hold, otherwise increments
// (wrapping from 16'hFFFF to 16'h0000).
module pc_register #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_hold,
  input  logic [15:0] i_load_value,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_hold) begin
      r_count <= r_count;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Byte-serial instruction fetch: assembles opcode plus 0-2 operand bytes from ROM.
// Optional halt support is enabled by defining FETCH_STAGE_HALT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [7:0]  NOP_OPCODE   = DEFAULT_NOP_OPCODE,
  parameter logic [7:0]  HALT_OPCODE  = DEFAULT_HALT_OPCODE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BRANCH,
  input  logic [15:0] BRANCH_TARGET,
  output logic [15:0] MEM_ADDR,
  input  logic [7:0]  MEM_DATA,
  output logic [7:0]  OPCODE_OUT,
  output logic [15:0] OPERAND_OUT,
  output logic [15:0] INSTR_PC
);

`ifdef FETCH_STAGE_HALT_EN
  localparam logic HALT_ENABLED = 1'b1;
`else
  localparam logic HALT_ENABLED = 1'b0;
`endif

  fetch_state_t r_state, w_state_nx;
  logic [7:0]  r_held_op, w_held_op_nx;
  logic [15:0] r_held_pc, w_held_pc_nx;
  logic [7:0]  r_lo, w_lo_nx;
  logic [7:0]  r_opcode, w_opcode_nx;
  logic [15:0] r_operand, w_operand_nx;
  logic [15:0] r_instr_pc, w_instr_pc_nx;
  logic [15:0] w_pc;
  logic        w_pc_hold;
  logic [1:0]  w_fetch_cnt;
  logic [1:0]  w_held_cnt;
  logic        w_halt_hit;

  pc_register #(
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_load       (BRANCH),
    .i_hold       (w_pc_hold),
    .i_load_value (BRANCH_TARGET),
    .o_count      (w_pc)
  );

  assign w_fetch_cnt = operand_count(MEM_DATA[OPCNT_MSB:OPCNT_LSB]);
  assign w_held_cnt  = operand_count(r_held_op[OPCNT_MSB:OPCNT_LSB]);
  assign w_halt_hit  = HALT_ENABLED & (MEM_DATA == HALT_OPCODE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_FETCH;
      r_held_op  <= NOP_OPCODE;
      r_held_pc  <= RESET_VECTOR;
      r_lo       <= 8'h00;
      r_opcode   <= NOP_OPCODE;
      r_operand  <= 16'h0000;
      r_instr_pc <= RESET_VECTOR;
    end else begin
      r_state    <= w_state_nx;
      r_held_op  <= w_held_op_nx;
      r_held_pc  <= w_held_pc_nx;
      r_lo       <= w_lo_nx;
      r_opcode   <= w_opcode_nx;
      r_operand  <= w_operand_nx;
      r_instr_pc <= w_instr_pc_nx;
    end
  end

  // Branch outranks stall; a stall simply keeps every default (hold) value.
  always_comb begin
    w_state_nx    = r_state;
    w_held_op_nx  = r_held_op;
    w_held_pc_nx  = r_held_pc;
    w_lo_nx       = r_lo;
    w_opcode_nx   = r_opcode;
    w_operand_nx  = r_operand;
    w_instr_pc_nx = r_instr_pc;
    w_pc_hold     = 1'b0;
    if (BRANCH) begin
      w_state_nx  = ST_FETCH;
      w_opcode_nx = NOP_OPCODE;
    end else if (STALL) begin
      w_pc_hold = 1'b1;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if ((w_fetch_cnt == 2'd0) || w_halt_hit) begin
            w_opcode_nx   = MEM_DATA;
            w_operand_nx  = 16'h0000;
            w_instr_pc_nx = w_pc;
            w_state_nx    = w_halt_hit ? ST_HALTED : ST_FETCH;
          end else begin
            w_held_op_nx = MEM_DATA;
            w_held_pc_nx = w_pc;
            w_opcode_nx  = NOP_OPCODE;
            w_state_nx   = ST_OPER_LO;
          end
        end
        ST_OPER_LO: begin
          w_lo_nx = MEM_DATA;
          if (w_held_cnt == 2'd1) begin
            w_opcode_nx   = r_held_op;
            w_operand_nx  = {8'h00, MEM_DATA};
            w_instr_pc_nx = r_held_pc;
            w_state_nx    = ST_FETCH;
          end else begin
            w_opcode_nx = NOP_OPCODE;
            w_state_nx  = ST_OPER_HI;
          end
        end
        ST_OPER_HI: begin
          w_opcode_nx   = r_held_op;
          w_operand_nx  = {MEM_DATA, r_lo};
          w_instr_pc_nx = r_held_pc;
          w_state_nx    = ST_FETCH;
        end
        ST_HALTED: begin
          w_pc_hold   = 1'b1;
          w_opcode_nx = NOP_OPCODE;
        end
        default: begin
          w_pc_hold   = 1'b1;
          w_opcode_nx = NOP_OPCODE;
          w_state_nx  = ST_FETCH;
        end
      endcase
    end
  end

  assign MEM_ADDR    = w_pc;
  assign OPCODE_OUT  = r_opcode;
  assign OPERAND_OUT = r_operand;
  assign INSTR_PC    = r_instr_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal pins plus
// randomized control against a byte-accumulating instruction model.
module tb_fetch_stage;

`ifdef FETCH_STAGE_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [15:0] RV = 16'h0000;

  logic        CLK = 1'b0;
  logic        RST, STALL, BRANCH;
  logic [15:0] BRANCH_TARGET;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic [7:0]  OPCODE_OUT;
  logic [15:0] OPERAND_OUT;
  logic [15:0] INSTR_PC;

  logic [7:0] rom [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the instruction decoded so far, as a list of bytes.
  logic [15:0] m_pc, m_start, exp_operand, exp_ipc;
  logic [7:0]  exp_op, m_op;
  logic [7:0]  m_bytes [0:2];
  int          m_got, m_need;
  bit          m_halted, m_halt_instr;

  always #5 CLK = ~CLK;

  assign MEM_DATA = rom[MEM_ADDR];

  fetch_stage dut (
    .CLK           (CLK),
    .RST           (RST),
    .STALL         (STALL),
    .BRANCH        (BRANCH),
    .BRANCH_TARGET (BRANCH_TARGET),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_DATA      (MEM_DATA),
    .OPCODE_OUT    (OPCODE_OUT),
    .OPERAND_OUT   (OPERAND_OUT),
    .INSTR_PC      (INSTR_PC)
  );

  function automatic int opnd_count(input logic [7:0] op);
    int n;
    n = int'(op >> 6);
    if (n == 3) n = 2;
    return n;
  endfunction

  task automatic model_step();
    logic [7:0] b;
    if (RST) begin
      m_pc = RV; m_got = 0; m_halted = 1'b0;
      exp_op = 8'h00; exp_operand = 16'h0000; exp_ipc = RV;
    end else if (BRANCH) begin
      m_pc = BRANCH_TARGET; m_got = 0; m_halted = 1'b0; exp_op = 8'h00;
    end else if (STALL) begin
      m_pc = m_pc;
    end else if (m_halted) begin
      exp_op = 8'h00;
    end else begin
      b = rom[m_pc];
      if (m_got == 0) begin
        m_op = b;
        m_start = m_pc;
        m_halt_instr = HALT_EN && (b == 8'hFF);
        m_need = m_halt_instr ? 0 : opnd_count(b);
      end
      m_bytes[m_got] = b;
      m_got = m_got + 1;
      m_pc = m_pc + 16'd1;
      if (m_got == m_need + 1) begin
        exp_op  = m_op;
        exp_ipc = m_start;
        if (m_need == 0)      exp_operand = 16'h0000;
        else if (m_need == 1) exp_operand = {8'h00, m_bytes[1]};
        else                  exp_operand = {m_bytes[2], m_bytes[1]};
        m_got = 0;
        if (m_halt_instr) m_halted = 1'b1;
      end else begin
        exp_op = 8'h00;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("mem_addr", MEM_ADDR, m_pc);
    check("opcode", {8'h00, OPCODE_OUT}, {8'h00, exp_op});
    check("operand", OPERAND_OUT, exp_operand);
    check("instr_pc", INSTR_PC, exp_ipc);
  endtask

  task automatic expect_lit(input string nm, input logic [7:0] op, input logic [15:0] opr,
                            input logic [15:0] ipc, input logic [15:0] addr);
    check({nm, ".opcode"}, {8'h00, OPCODE_OUT}, {8'h00, op});
    check({nm, ".operand"}, OPERAND_OUT, opr);
    check({nm, ".instr_pc"}, INSTR_PC, ipc);
    check({nm, ".mem_addr"}, MEM_ADDR, addr);
  endtask

  task automatic drive(input logic r, input logic b, input logic [15:0] t, input logic s);
    RST = r; BRANCH = b; BRANCH_TARGET = t; STALL = s;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_model();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    @(negedge CLK);

    // Reset and straight-line decode
    rom[0] = 8'h01; rom[1] = 8'h42; rom[2] = 8'h80; rom[3] = 8'h34; rom[4] = 8'h12;
    tick(); expect_lit("reset", 8'h00, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(); expect_lit("seq1", 8'h01, 16'h0000, 16'h0000, 16'h0001);
    tick(); expect_lit("seq2", 8'h00, 16'h0000, 16'h0000, 16'h0002);
    tick(); expect_lit("seq3", 8'h42, 16'h0080, 16'h0001, 16'h0003);
    tick(); expect_lit("seq4", 8'h34, 16'h0000, 16'h0003, 16'h0004);
    tick(); expect_lit("seq5", 8'h12, 16'h0000, 16'h0004, 16'h0005);

    // Stall in OPER_LO
    rom[16'h0100] = 8'h42; rom[16'h0101] = 8'h5A; rom[16'h0102] = 8'h00;
    drive(1'b0, 1'b1, 16'h0100, 1'b0);
    tick(); expect_lit("br100", 8'h00, 16'h0000, 16'h0004, 16'h0100);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(); expect_lit("opl", 8'h00, 16'h0000, 16'h0004, 16'h0101);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_lit("stall", 8'h00, 16'h0000, 16'h0004, 16'h0101);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(); expect_lit("unstall", 8'h42, 16'h005A, 16'h0100, 16'h0102);

    // Branch out of OPER_HI
    rom[16'h0200] = 8'hC0; rom[16'h0201] = 8'h11; rom[16'h0202] = 8'h22; rom[16'h2000] = 8'h05;
    drive(1'b0, 1'b1, 16'h0200, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick(); tick();
    drive(1'b0, 1'b1, 16'h2000, 1'b0);
    tick(); expect_lit("br_hi", 8'h00, 16'h005A, 16'h0100, 16'h2000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(); expect_lit("after_br", 8'h05, 16'h0000, 16'h2000, 16'h2001);

    // Operand across the PC wrap
    rom[16'hFFFF] = 8'h41; rom[16'h0000] = 8'h77; rom[16'h0001] = 8'h03;
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();
    tick(); expect_lit("wrap", 8'h41, 16'h0077, 16'hFFFF, 16'h0001);

    // Halt opcode (ordinary two-operand opcode when halt support is absent)
    rom[16'h0010] = 8'hFF; rom[16'h0011] = 8'h33; rom[16'h0012] = 8'h44; rom[16'h0013] = 8'h06;
    drive(1'b0, 1'b1, 16'h0010, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    if (HALT_EN) begin
      tick(); expect_lit("halt", 8'hFF, 16'h0000, 16'h0010, 16'h0011);
      for (int i = 0; i < 3; i++) begin
        tick(); expect_lit("halted", 8'h00, 16'h0000, 16'h0010, 16'h0011);
      end
    end else begin
      tick(); tick();
      tick(); expect_lit("ff_op", 8'hFF, 16'h4433, 16'h0010, 16'h0013);
    end
    drive(1'b0, 1'b1, 16'h0013, 1'b0); tick();

    // Reset with branch and stall in OPER_HI
    rom[16'h0300] = 8'hC1; rom[16'h0301] = 8'h01; rom[16'h0302] = 8'h02;
    drive(1'b0, 1'b1, 16'h0300, 1'b0); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick(); tick();
    drive(1'b1, 1'b1, 16'h1234, 1'b1);
    tick(); expect_lit("rst_all", 8'h00, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0); tick();

    // Randomized control and ROM contents
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom),
            ($urandom_range(0, 99) < 20));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
